multi_tap_line_buffer: RTL and testbench

MULTI_TAP_LINE_BUFFER -- requirements
Module: multi_tap_line_buffer

---
 rtl/cnn_pkg.sv | 40 ++++
 rtl/line_delay.sv | 60 ++++++
 rtl/multi_tap_line_buffer.sv | 142 ++++++++++++++
 tb/tb_multi_tap_line_buffer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared helper constants for the CNN line-buffer slice: tap slice width,
// pointer width, depth register width, fill-count width and depth clamping.
package cnn_pkg;

    // Bits carried per tap: all channels of one sample side by side.
    function automatic int tap_slice_w(input int width, input int ch);
        return width * ch;
    endfunction

    // Circular-buffer pointer width; a one-entry line still needs one bit.
    function automatic int ptr_w(input int max_depth);
        if (max_depth > 1) begin
            return $clog2(max_depth);
        end else begin
            return 1;
        end
    endfunction

    // Width of the runtime depth value (must represent MAX_DEPTH itself).
    function automatic int depth_w(input int max_depth);
        return $clog2(max_depth + 1);
    endfunction

    // Fill counter width: counts up to (TAPS-1)*MAX_DEPTH+1 inclusive.
    function automatic int count_w(input int taps, input int max_depth);
        return $clog2((taps - 1) * max_depth + 2);
    endfunction

    // Maps a requested depth into the legal range 1..max_depth.
    function automatic int clamp_depth(input int cfg, input int max_depth);
        if (cfg < 1) begin
            return 1;
        end else if (cfg > max_depth) begin
            return max_depth;
        end else begin
            return cfg;
        end
    endfunction

endpackage

// File: rtl/line_delay.sv
// One image line of delay held in a circular buffer. Only the pointer moves
// per sample: the oldest entry is read out while the new one overwrites it.
module line_delay
    import cnn_pkg::*;
#(
    parameter int SW        = 8,
    parameter int MAX_DEPTH = 28,
    localparam int DW       = depth_w(MAX_DEPTH),
    localparam int PW       = ptr_w(MAX_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          shift,
    input  logic [DW-1:0] depth,
    input  logic [SW-1:0] din,
    output logic [SW-1:0] dout
);

    logic [SW-1:0] mem_r [MAX_DEPTH];
    logic [PW-1:0] ptr_r;
    logic          last_s;

    // Detect the final slot of the active line so the pointer wraps to 0.
    always_comb begin
        last_s = 1'b0;
        if (DW'(ptr_r) >= (depth - DW'(1))) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Pointer advances once per accepted sample; cleared by reset or flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= '0;
        end else if (clr) begin
            ptr_r <= '0;
        end else if (shift) begin
            if (last_s) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= ptr_r + PW'(1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Line storage: contents are never cleared, validity is tracked upstream.
    always_ff @(posedge clk) begin
        if (shift) begin
            mem_r[ptr_r] <= din;
        end
    end

    assign dout = mem_r[ptr_r];

endmodule

// File: rtl/multi_tap_line_buffer.sv
// Multi-tap line buffer: presents TAPS vertically aligned samples (one per
// line, D samples apart) for a sliding-window kernel. Tap 0 is the newest
// sample; tap k comes out of the k-th chained line delay.
module multi_tap_line_buffer
    import cnn_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CH        = 1,
    parameter int MAX_DEPTH = 28,
    parameter int TAPS      = 3,
    localparam int DW       = depth_w(MAX_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic                       flush,
    input  logic [DW-1:0]              cfg_depth,
    input  logic                       in_vld,
    input  logic [WIDTH*CH-1:0]        din,
    output logic [WIDTH*CH*TAPS-1:0]   dout,
    output logic                       out_vld,
    output logic                       filled
);

    localparam int SW = tap_slice_w(WIDTH, CH);
    localparam int CW = count_w(TAPS, MAX_DEPTH);

    logic              accept_s;
    logic              clear_s;
    logic              loaded_r;
    logic [DW-1:0]     depth_r;
    logic [DW-1:0]     cfg_clamp_s;
    logic [DW-1:0]     depth_s;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_next_s;
    logic [CW-1:0]     full_s;
    logic              reach_s;
    logic [SW-1:0]     chain_s [TAPS];
    logic [SW*TAPS-1:0] dout_r;
    logic              out_vld_r;
    logic              filled_r;

    // Flush wins over a coincident sample; ce low freezes everything.
    assign accept_s = ce & in_vld & ~flush;
    assign clear_s  = ce & flush;

    // Active depth: the latched value, or the live clamped request on the
    // very first edge after reset release (the edge that latches it).
    always_comb begin
        cfg_clamp_s = DW'(clamp_depth(int'(cfg_depth), MAX_DEPTH));
        depth_s     = depth_r;
        if (loaded_r) begin
            depth_s = depth_r;
        end else begin
            depth_s = cfg_clamp_s;
        end
    end

    // Fill threshold and saturating next count for an accepted sample.
    always_comb begin
        full_s       = CW'((TAPS - 1) * int'(depth_s) + 1);
        count_next_s = count_r;
        if (count_r < full_s) begin
            count_next_s = count_r + CW'(1);
        end else begin
            count_next_s = count_r;
        end
        reach_s = (count_next_s >= full_s);
    end

    // Latch the line depth on the first edge after reset and on every flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            loaded_r <= 1'b0;
            depth_r  <= DW'(1);
        end else if (!loaded_r || clear_s) begin
            loaded_r <= 1'b1;
            depth_r  <= cfg_clamp_s;
        end else begin
            loaded_r <= loaded_r;
            depth_r  <= depth_r;
        end
    end

    // Fill count plus valid/filled flags; valid pulses only after an accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r   <= '0;
            out_vld_r <= 1'b0;
            filled_r  <= 1'b0;
        end else if (clear_s) begin
            count_r   <= '0;
            out_vld_r <= 1'b0;
            filled_r  <= 1'b0;
        end else if (accept_s) begin
            count_r   <= count_next_s;
            out_vld_r <= reach_s;
            filled_r  <= reach_s;
        end else begin
            count_r   <= count_r;
            out_vld_r <= 1'b0;
            filled_r  <= filled_r;
        end
    end

    assign chain_s[0] = din;

    // Lines chained in series: each one feeds the sample that falls out of
    // the previous line into the next, giving k*D of delay on tap k.
    for (genvar k = 1; k < TAPS; k++) begin : g_line
        line_delay #(
            .SW        (SW),
            .MAX_DEPTH (MAX_DEPTH)
        ) u_line (
            .clk   (clk),
            .rst   (rst),
            .clr   (clear_s),
            .shift (accept_s),
            .depth (depth_s),
            .din   (chain_s[k-1]),
            .dout  (chain_s[k])
        );
    end

    // Tap output register: captures all taps together on each accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_r <= '0;
        end else if (accept_s) begin
            for (int k = 0; k < TAPS; k++) begin
                dout_r[k*SW +: SW] <= chain_s[k];
            end
        end else begin
            dout_r <= dout_r;
        end
    end

    assign dout    = dout_r;
    assign out_vld = out_vld_r;
    assign filled  = filled_r;

endmodule

// File: tb/tb_multi_tap_line_buffer.sv
// Scoreboard bench for multi_tap_line_buffer (CH=2, TAPS=3, MAX_DEPTH=28).
// Channel 0 carries the sample index since the last reset/flush, channel 1
// carries index+100, so tap k after sample n is {n-k*D+100, n-k*D}.
module tb_multi_tap_line_buffer;

    localparam int WIDTH     = 8;
    localparam int CH        = 2;
    localparam int MAX_DEPTH = 28;
    localparam int TAPS      = 3;
    localparam int SW        = WIDTH * CH;
    localparam int OW        = SW * TAPS;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic          flush;
    logic [4:0]    cfg_depth;
    logic          in_vld;
    logic [SW-1:0] din;
    logic [OW-1:0] dout;
    logic          out_vld;
    logic          filled;

    int errors = 0;
    int checks = 0;
    int n      = 0;
    int cur_d  = 4;
    logic [OW-1:0] exp_q [$];

    multi_tap_line_buffer #(
        .WIDTH     (WIDTH),
        .CH        (CH),
        .MAX_DEPTH (MAX_DEPTH),
        .TAPS      (TAPS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .flush     (flush),
        .cfg_depth (cfg_depth),
        .in_vld    (in_vld),
        .din       (din),
        .dout      (dout),
        .out_vld   (out_vld),
        .filled    (filled)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] taps_for(input int idx, input int d);
        logic [OW-1:0] r;
        r = '0;
        for (int k = 0; k < TAPS; k++) begin
            int m;
            m = idx - k * d;
            r[k*SW +: SW] = {8'(m + 100), 8'(m)};
        end
        return r;
    endfunction

    task automatic check_vec(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: every presented output must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && out_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_vld: got out_vld=1 dout=%h expected no output", dout);
            end else begin
                check_vec("taps", dout, exp_q.pop_front());
            end
        end
    end

    // One input cycle; predicts the response of an accepted sample.
    task automatic step(input logic v, input logic c, input logic f);
        @(negedge clk);
        in_vld = v;
        ce     = c;
        flush  = f;
        din    = SW'($urandom);
        if (c && f) begin
            n = 0;
        end else if (c && v) begin
            n++;
            din = {8'(n + 100), 8'(n)};
            if (n >= (TAPS - 1) * cur_d + 1) begin
                exp_q.push_back(taps_for(n, cur_d));
            end
        end
    endtask

    task automatic feed(input int cnt);
        repeat (cnt) step(1'b1, 1'b1, 1'b0);
    endtask

    task automatic do_flush(input logic [4:0] cfg, input int d);
        cfg_depth = cfg;
        cur_d     = d;
        step(1'b0, 1'b1, 1'b1);
    endtask

    task automatic drain(input string name);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_out_vld: got %0d outputs pending expected 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        ce        = 1'b0;
        flush     = 1'b0;
        in_vld    = 1'b0;
        din       = '0;
        cfg_depth = 5'd4;
        cur_d     = 4;
        repeat (2) @(negedge clk);
        #1;
        check_vec("reset_dout", dout, '0);
        check_bit("reset_out_vld", out_vld, 1'b0);
        check_bit("reset_filled", filled, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        n   = 0;

        // D=4, continuous stream: first output after sample 9.
        feed(8);
        step(1'b1, 1'b1, 1'b0);
        check_bit("t1_not_filled_at_8", filled, 1'b0);
        check_bit("t1_no_vld_at_8", out_vld, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_vec("t1_taps_9_5_1", dout, 48'h6501_6905_6D09);
        check_bit("t1_filled_at_9", filled, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        check_vec("t1_taps_10_6_2", dout, 48'h6602_6A06_6E0A);
        feed(2);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_bit("t1_vld_drops_when_idle", out_vld, 1'b0);
        check_vec("t1_dout_holds_12", dout, 48'h6804_6C08_700C);
        drain("t1");

        // Same stream with in_vld toggling and ce low for 3 cycles.
        do_flush(5'd4, 4);
        step(1'b0, 1'b1, 1'b0);
        check_bit("t2_flush_clears_filled", filled, 1'b0);
        for (int i = 0; i < 100 && n < 12; i++) begin
            if (i >= 7 && i <= 9) begin
                step(1'b1, 1'b0, 1'b0);
            end else begin
                step(logic'(i % 2 == 0), 1'b1, 1'b0);
            end
        end
        drain("t2");

        // Flush coincident with sample 6, new depth 2.
        do_flush(5'd4, 4);
        feed(5);
        cfg_depth = 5'd2;
        cur_d     = 2;
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        check_bit("t3_flush_no_vld", out_vld, 1'b0);
        check_bit("t3_flush_no_filled", filled, 1'b0);
        feed(4);
        step(1'b0, 1'b1, 1'b0);
        check_bit("t3_no_vld_after_4", out_vld, 1'b0);
        feed(1);
        step(1'b0, 1'b1, 1'b0);
        check_vec("t3_taps_5_3_1", dout, 48'h6501_6703_6905);
        feed(2);
        drain("t3");

        // cfg_depth=0 behaves as D=1.
        do_flush(5'd0, 1);
        feed(2);
        step(1'b0, 1'b1, 1'b0);
        check_bit("t4_d1_not_filled", filled, 1'b0);
        feed(3);
        drain("t4a");
        check_bit("t4_d1_filled", filled, 1'b1);

        // Largest encodable request (31 > MAX_DEPTH) behaves as D=28;
        // a mid-stream cfg_depth change must be ignored.
        do_flush(5'd31, 28);
        feed(30);
        cfg_depth = 5'd3;
        feed(26);
        step(1'b0, 1'b1, 1'b0);
        check_bit("t4_d28_not_filled_at_56", filled, 1'b0);
        feed(2);
        drain("t4b");
        check_bit("t4_d28_filled", filled, 1'b1);

        // Reset asserted mid-stream just after sample 7.
        do_flush(5'd4, 4);
        feed(7);
        @(posedge clk);
        #2;
        in_vld = 1'b0;
        rst    = 1'b0;
        #1;
        check_vec("t5_reset_dout", dout, '0);
        check_bit("t5_reset_out_vld", out_vld, 1'b0);
        check_bit("t5_reset_filled", filled, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        n   = 0;
        feed(8);
        step(1'b0, 1'b1, 1'b0);
        check_bit("t5_no_vld_after_8", out_vld, 1'b0);
        feed(2);
        drain("t5");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
